// File: rtl/mandelbrot_frame_scheduler_pkg.sv
// Shared types and default widths for the mandelbrot frame scheduler and core.
package mandelbrot_pkg;

  localparam int BITWIDTH_DEF = 11;
  localparam int CTRWIDTH_DEF = 7;
  localparam int XW_DEF       = 7;
  localparam int YW_DEF       = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } sched_state_t;

  // Result entry held in the output FIFO. Field widths are the upper bounds
  // for the scheduler's CTRWIDTH/XW/YW parameters.
  typedef struct packed {
    logic [CTRWIDTH_DEF-1:0] ctr;
    logic [XW_DEF-1:0]       x;
    logic [YW_DEF-1:0]       y;
    logic                    last;
  } pix_entry_t;

endpackage

// File: rtl/mandelbrot_frame_scheduler_if.sv
// Core launch/result signals plus the tagged pixel output stream.
interface mandelbrot_frame_scheduler_if #(
  parameter int BITWIDTH = 11,
  parameter int CTRWIDTH = 7,
  parameter int XW       = 7,
  parameter int YW       = 6
) ();

  logic                core_run;
  logic [BITWIDTH-1:0] core_cr;
  logic [BITWIDTH-1:0] core_ci;
  logic                core_new_ctr;
  logic [CTRWIDTH-1:0] core_ctr;

  logic                pix_valid;
  logic                pix_ready;
  logic [CTRWIDTH-1:0] pix_ctr;
  logic [XW-1:0]       pix_x;
  logic [YW-1:0]       pix_y;
  logic                pix_last;

  // Scheduler side: drives the core launch and the pixel stream.
  modport master (
    output core_run, core_cr, core_ci,
    input  core_new_ctr, core_ctr,
    output pix_valid, pix_ctr, pix_x, pix_y, pix_last,
    input  pix_ready
  );

  // Core and pixel consumer side.
  modport slave (
    input  core_run, core_cr, core_ci,
    output core_new_ctr, core_ctr,
    input  pix_valid, pix_ctr, pix_x, pix_y, pix_last,
    output pix_ready
  );

endinterface

// File: rtl/mandelbrot_frame_scheduler_chk.sv
// Protocol checks for the 2-entry result FIFO.
module result_fifo2_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       push,
  input logic       pop,
  input logic [1:0] count
);

  // A push into a full FIFO without a simultaneous pop would lose a result.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == 2'd2)));

  // The occupancy counter never reaches its unused encoding.
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count != 2'd3);

endmodule

// File: rtl/mandelbrot_frame_scheduler_result_fifo2.sv
// Two-entry valid/ready FIFO with registered head; exposes its occupancy.
module result_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic [1:0]    count
);

  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [1:0]    count_q, count_d;
  logic          pop_s;

  assign pop_s = (count_q != 2'd0) && ready;
  assign valid = (count_q != 2'd0);
  assign dout  = head_q;
  assign count = count_q;

  // Next-state: the head always holds the oldest entry; pop shifts tail into head.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_d  = din;
            count_d = 2'd1;
          end else begin
            count_d = 2'd0;
          end
        end
        2'd1: begin
          if (push && pop_s) begin
            head_d  = din;
            count_d = 2'd1;
          end else if (push) begin
            tail_d  = din;
            count_d = 2'd2;
          end else if (pop_s) begin
            count_d = 2'd0;
          end else begin
            count_d = 2'd1;
          end
        end
        2'd2: begin
          if (pop_s) begin
            head_d = tail_q;
            if (push) begin
              tail_d  = din;
              count_d = 2'd2;
            end else begin
              count_d = 2'd1;
            end
          end else begin
            // push without pop here is an overflow; the entry is dropped
            count_d = 2'd2;
          end
        end
        default: begin
          count_d = 2'd0;
        end
      endcase
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  result_fifo2_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push && !flush),
    .pop   (pop_s),
    .count (count_q)
  );

endmodule

// File: rtl/mandelbrot_frame_scheduler.sv
// Walks an XRES x YRES raster, launching the mandelbrot core once per pixel
// and queuing coordinate-tagged results for a valid/ready consumer.
module mandelbrot_frame_scheduler
  import mandelbrot_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEF,
  parameter int CTRWIDTH = CTRWIDTH_DEF,
  parameter int XRES     = 80,
  parameter int YRES     = 60,
  parameter int XW       = XW_DEF,
  parameter int YW       = YW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [BITWIDTH-1:0] cr_start,
  input  logic [BITWIDTH-1:0] ci_start,
  input  logic [BITWIDTH-1:0] step,
  output logic                busy,
  output logic                frame_done,
  mandelbrot_frame_scheduler_if.master bus
);

  localparam logic [XW-1:0] X_LAST = XW'(XRES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(YRES - 1);

  sched_state_t        state_q, state_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                core_run_q, core_run_d;
  logic [BITWIDTH-1:0] core_cr_q, core_cr_d;
  logic [BITWIDTH-1:0] core_ci_q, core_ci_d;
  logic [BITWIDTH-1:0] cr0_q, cr0_d;
  logic [BITWIDTH-1:0] step_q, step_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;

  logic                is_last_s;
  logic                push_s;
  logic                pop_s;
  pix_entry_t          entry_s;
  pix_entry_t          head_s;
  logic                fifo_valid_s;
  logic [$bits(pix_entry_t)-1:0] fifo_dout_s;
  logic [1:0]          fifo_count_s;

  assign is_last_s = (x_q == X_LAST) && (y_q == Y_LAST);
  // abort wins over a result arriving in the same cycle
  assign push_s    = (state_q == ST_WAIT) && bus.core_new_ctr && !abort;
  assign pop_s     = fifo_valid_s && bus.pix_ready;
  assign head_s    = pix_entry_t'(fifo_dout_s);

  // Pack the core result with the coordinates of the pixel in flight.
  always_comb begin
    entry_s      = '0;
    entry_s.ctr  = CTRWIDTH_DEF'(bus.core_ctr);
    entry_s.x    = XW_DEF'(x_q);
    entry_s.y    = YW_DEF'(y_q);
    entry_s.last = is_last_s;
  end

  // Frame sequencing and incremental coordinate stepping.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    core_run_d   = 1'b0;
    core_cr_d    = core_cr_q;
    core_ci_d    = core_ci_q;
    cr0_d        = cr0_q;
    step_d       = step_q;
    x_d          = x_q;
    y_d          = y_q;
    if (abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cr0_d     = cr_start;
            step_d    = step;
            core_cr_d = cr_start;
            core_ci_d = ci_start;
            x_d       = '0;
            y_d       = '0;
            busy_d    = 1'b1;
            state_d   = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // at most one entry queued leaves room for the result in flight
          if (fifo_count_s <= 2'd1) begin
            core_run_d = 1'b1;
            state_d    = ST_WAIT;
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (bus.core_new_ctr) begin
            if (is_last_s) begin
              state_d = ST_FLUSH;
            end else if (x_q == X_LAST) begin
              x_d       = '0;
              y_d       = y_q + YW'(1);
              core_cr_d = cr0_q;
              core_ci_d = core_ci_q - step_q;
              state_d   = ST_ISSUE;
            end else begin
              x_d       = x_q + XW'(1);
              core_cr_d = core_cr_q + step_q;
              state_d   = ST_ISSUE;
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_FLUSH: begin
          if (pop_s && head_s.last) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_FLUSH;
          end
        end
        default: begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Scheduler state, coordinate and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      core_run_q   <= 1'b0;
      core_cr_q    <= '0;
      core_ci_q    <= '0;
      cr0_q        <= '0;
      step_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      core_run_q   <= core_run_d;
      core_cr_q    <= core_cr_d;
      core_ci_q    <= core_ci_d;
      cr0_q        <= cr0_d;
      step_q       <= step_d;
      x_q          <= x_d;
      y_q          <= y_d;
    end
  end

  result_fifo2 #(
    .DW ($bits(pix_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (push_s),
    .din   (entry_s),
    .ready (bus.pix_ready),
    .valid (fifo_valid_s),
    .dout  (fifo_dout_s),
    .count (fifo_count_s)
  );

  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign bus.core_run  = core_run_q;
  assign bus.core_cr   = core_cr_q;
  assign bus.core_ci   = core_ci_q;
  assign bus.pix_valid = fifo_valid_s;
  assign bus.pix_ctr   = head_s.ctr[CTRWIDTH-1:0];
  assign bus.pix_x     = head_s.x[XW-1:0];
  assign bus.pix_y     = head_s.y[YW-1:0];
  assign bus.pix_last  = head_s.last;

endmodule

// File: tb/tb_mandelbrot_frame_scheduler.sv
// Bench for mandelbrot_frame_scheduler on a 4x3 raster with a 5-cycle core model.
module tb_mandelbrot_frame_scheduler;

  localparam int XR = 4;
  localparam int YR = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [10:0] cr_start, ci_start, step;
  logic        busy, frame_done;

  mandelbrot_frame_scheduler_if #(.BITWIDTH(11), .CTRWIDTH(7), .XW(7), .YW(6)) bus_if ();

  mandelbrot_frame_scheduler #(
    .BITWIDTH(11), .CTRWIDTH(7), .XRES(XR), .YRES(YR), .XW(7), .YW(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cr_start(cr_start), .ci_start(ci_start), .step(step),
    .busy(busy), .frame_done(frame_done), .bus(bus_if)
  );

  // standalone FIFO for the full push+pop corner, unreachable through the top
  logic       u_flush, u_push, u_ready, u_valid;
  logic [7:0] u_din, u_dout;
  logic [1:0] u_count;

  result_fifo2 #(.DW(8)) u_unit (
    .clk(clk), .rst_n(rst_n), .flush(u_flush), .push(u_push), .din(u_din),
    .ready(u_ready), .valid(u_valid), .dout(u_dout), .count(u_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] ctr;
    logic [6:0] x;
    logic [5:0] y;
    logic       last;
  } exp_t;

  exp_t        sb_q[$];
  logic [10:0] run_cr[$];
  logic [10:0] run_ci[$];
  int          tests = 0;
  int          fails = 0;
  int          runs = 0;
  int          npix = 0;
  int          done_cnt = 0;
  int          runs0 = 0;
  int          pix0 = 0;
  int          mx = 0;
  int          my = 0;
  logic [10:0] m_cr0 = 11'h0;
  logic [10:0] m_ci0 = 11'h0;
  logic [10:0] m_step = 11'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Core model: checks launch coordinates, returns ctr=x+y five cycles later.
  initial begin : core_model
    int   cnt;
    bit   pend;
    logic prev_run;
    logic [6:0]  pctr;
    logic [10:0] e_cr, e_ci;
    cnt = 0; pend = 1'b0; prev_run = 1'b0; pctr = 7'd0;
    bus_if.core_new_ctr = 1'b0;
    bus_if.core_ctr = 7'd0;
    forever begin
      @(negedge clk);
      bus_if.core_new_ctr = 1'b0;
      if (!rst_n) pend = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus_if.core_new_ctr = 1'b1;
          bus_if.core_ctr = pctr;
          pend = 1'b0;
        end
      end
      if (bus_if.core_run) begin
        check("core_run_single", 64'(prev_run), 64'd0);
        e_cr = m_cr0 + m_step * 11'(mx);
        e_ci = m_ci0 - m_step * 11'(my);
        check("core_cr", 64'(bus_if.core_cr), 64'(e_cr));
        check("core_ci", 64'(bus_if.core_ci), 64'(e_ci));
        run_cr.push_back(bus_if.core_cr);
        run_ci.push_back(bus_if.core_ci);
        pctr = 7'(mx + my);
        sb_q.push_back({pctr, 7'(mx), 6'(my), (mx == XR - 1) && (my == YR - 1)});
        runs++;
        if (mx == XR - 1) begin mx = 0; my++; end
        else mx++;
        pend = 1'b1;
        cnt = 5;
      end
      prev_run = bus_if.core_run;
    end
  end

  // Output monitor: scoreboard pops, hold-under-backpressure, frame_done.
  initial begin : monitor
    logic        hold_prev;
    logic [21:0] prev_pack, cur_pack;
    exp_t        e;
    hold_prev = 1'b0; prev_pack = '0;
    forever begin
      @(negedge clk);
      cur_pack = {bus_if.pix_valid, bus_if.pix_ctr, bus_if.pix_x, bus_if.pix_y, bus_if.pix_last};
      if (hold_prev && rst_n) check("pix_hold", 64'(cur_pack), 64'(prev_pack));
      if (frame_done) begin
        done_cnt++;
        check("done_busy_low", 64'(busy), 64'd0);
      end
      if (bus_if.pix_valid && bus_if.pix_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_extra_pixel", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          check("pixel", 64'(cur_pack[20:0]), 64'(e));
          npix++;
        end
      end
      hold_prev = bus_if.pix_valid && !bus_if.pix_ready && rst_n;
      prev_pack = cur_pack;
    end
  end

  task automatic start_frame(input logic [10:0] c, input logic [10:0] i, input logic [10:0] s);
    m_cr0 = c; m_ci0 = i; m_step = s; mx = 0; my = 0;
    run_cr.delete(); run_ci.delete();
    runs0 = runs; pix0 = npix;
    cr_start = c; ci_start = i; step = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    // later input changes must not leak into the frame
    cr_start = 11'h5A5; ci_start = 11'h2D2; step = 11'h333;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    int n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < 3000) begin tick(); n++; end
    repeat (4) tick();
    check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_pixels"}, 64'(npix - pix0), 64'(XR * YR));
    check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  typedef struct {
    logic [10:0] cr, ci, st;
    logic [10:0] e_cr1, e_cr3, e_ci_row1;
  } vec_t;

  typedef struct {
    logic       push, ready;
    logic [7:0] din;
    logic [1:0] e_count;
    logic       e_valid;
    logic [7:0] e_dout;
  } fvec_t;

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t  vec[3];
    fvec_t fv[9];
    int    r0;

    vec[0] = '{11'h700, 11'h100, 11'h010, 11'h710, 11'h730, 11'h0F0};
    vec[1] = '{11'h7F0, 11'h005, 11'h010, 11'h000, 11'h020, 11'h7F5};
    vec[2] = '{11'h000, 11'h000, 11'h7FF, 11'h7FF, 11'h7FD, 11'h001};

    fv[0] = '{1'b1, 1'b0, 8'h11, 2'd1, 1'b1, 8'h11};
    fv[1] = '{1'b1, 1'b0, 8'h22, 2'd2, 1'b1, 8'h11};
    fv[2] = '{1'b1, 1'b1, 8'h33, 2'd2, 1'b1, 8'h22};
    fv[3] = '{1'b0, 1'b0, 8'h00, 2'd2, 1'b1, 8'h22};
    fv[4] = '{1'b0, 1'b1, 8'h00, 2'd1, 1'b1, 8'h33};
    fv[5] = '{1'b1, 1'b1, 8'h44, 2'd1, 1'b1, 8'h44};
    fv[6] = '{1'b0, 1'b1, 8'h00, 2'd0, 1'b0, 8'h44};
    fv[7] = '{1'b1, 1'b0, 8'h55, 2'd1, 1'b1, 8'h55};
    fv[8] = '{1'b1, 1'b0, 8'h66, 2'd2, 1'b1, 8'h55};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cr_start = 11'h0; ci_start = 11'h0; step = 11'h0;
    bus_if.pix_ready = 1'b0;
    u_flush = 1'b0; u_push = 1'b0; u_ready = 1'b0; u_din = 8'h00;
    #12;
    check("reset_outs", 64'({busy, frame_done, bus_if.core_run, bus_if.core_cr, bus_if.core_ci,
                             bus_if.pix_valid, bus_if.pix_ctr, bus_if.pix_x, bus_if.pix_y,
                             bus_if.pix_last}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // FIFO unit: full push+pop, count-1 push+pop, drain, flush
    for (int i = 0; i < 9; i++) begin
      u_push = fv[i].push; u_ready = fv[i].ready; u_din = fv[i].din;
      tick();
      check($sformatf("fifo_step%0d", i), 64'({u_count, u_valid, u_dout}),
            64'({fv[i].e_count, fv[i].e_valid, fv[i].e_dout}));
    end
    u_push = 1'b0; u_ready = 1'b0; u_flush = 1'b1;
    tick();
    u_flush = 1'b0;
    check("fifo_flush", 64'({u_count, u_valid}), 64'd0);

    // Frame table, consumer always ready; start mid-frame must be ignored
    bus_if.pix_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      start_frame(vec[v].cr, vec[v].ci, vec[v].st);
      repeat (20) tick();
      cr_start = 11'h123;
      start = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("v%0d_busy_mid", v), 64'(busy), 64'd1);
      wait_done($sformatf("v%0d", v));
      check($sformatf("v%0d_runs", v), 64'(runs - runs0), 64'(XR * YR));
      if (run_cr.size() >= XR + 1) begin
        check($sformatf("v%0d_cr1", v), 64'(run_cr[1]), 64'(vec[v].e_cr1));
        check($sformatf("v%0d_cr3", v), 64'(run_cr[3]), 64'(vec[v].e_cr3));
        check($sformatf("v%0d_cr_row1", v), 64'(run_cr[XR]), 64'(vec[v].cr));
        check($sformatf("v%0d_ci_row1", v), 64'(run_ci[XR]), 64'(vec[v].e_ci_row1));
      end else begin
        check($sformatf("v%0d_run_list", v), 64'(run_cr.size()), 64'(XR * YR));
      end
    end

    // Backpressure: two results buffered, then ISSUE stalls
    bus_if.pix_ready = 1'b0;
    start_frame(11'h700, 11'h100, 11'h010);
    repeat (60) tick();
    check("bp_runs", 64'(runs - runs0), 64'd2);
    check("bp_busy", 64'(busy), 64'd1);
    check("bp_head", 64'({bus_if.pix_valid, bus_if.pix_x, bus_if.pix_y}), 64'({1'b1, 7'd0, 6'd0}));
    bus_if.pix_ready = 1'b1;
    wait_done("bp");

    // Abort during WAIT of pixel (2,1)
    start_frame(11'h700, 11'h100, 11'h010);
    r0 = 0;
    while (runs - runs0 < 2 * XR - 1 && r0 < 500) begin tick(); r0++; end
    check("ab_reached", 64'(runs - runs0), 64'(2 * XR - 1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_valid", 64'(bus_if.pix_valid), 64'd0);
    sb_q.delete();
    r0 = npix;
    repeat (10) tick();
    check("ab_late_ignored", 64'({bus_if.pix_valid, busy}), 64'd0);
    check("ab_no_pop", 64'(npix - r0), 64'd0);
    start_frame(11'h700, 11'h100, 11'h010);
    wait_done("ab_restart");

    // start and abort together in IDLE: stay idle
    r0 = runs;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (5) tick();
    check("sa_idle", 64'({busy, 7'(runs - r0)}), 64'd0);

    // Asynchronous reset mid-frame, then a clean frame
    start_frame(11'h7F0, 11'h005, 11'h010);
    repeat (15) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outs", 64'({busy, frame_done, bus_if.core_run, bus_if.core_cr, bus_if.core_ci,
                                 bus_if.pix_valid, bus_if.pix_ctr, bus_if.pix_x, bus_if.pix_y,
                                 bus_if.pix_last}), 64'd0);
    sb_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("rst_quiet", 64'({busy, bus_if.pix_valid}), 64'd0);
    start_frame(11'h700, 11'h100, 11'h010);
    wait_done("rst_frame");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
